// File: rtl/ingress_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one parser input between
// NUM_PORTS AXI-Stream ingress ports. A granted port keeps the parser until its
// tlast beat is accepted; m_tid tags the frame with its source port.
module ingress_frame_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  localparam int unsigned PW       = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]        s_tvalid,
  input  logic [NUM_PORTS-1:0]        s_tlast,
  output logic [NUM_PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic [PW-1:0]               m_tid,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        tid_q, tid_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] req;
  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [PW:0]          cand;
  logic                 streaming;
  logic                 last_accept;

  assign streaming = (state_q == StStream);
  assign req       = s_tvalid & port_en;

  // Round-robin search: first requesting port at or above rr_ptr, wrapping at NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(off);
      // Both operands are below NUM_PORTS, so one subtraction is a full modulo.
      if (cand >= (PW+1)'(NUM_PORTS)) begin
        cand = cand - (PW+1)'(NUM_PORTS);
      end
      if (!pick_found && req[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  // Grant mux: pass the owning port straight through; idle drives nothing valid.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (streaming) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (tid_q == PW'(i)) begin
          m_tdata     = s_tdata[i*DATA_W +: DATA_W];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  assign last_accept = m_tvalid & m_tready & m_tlast;

  // Next-state: grant in idle, release only on an accepted tlast beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    tid_d    = tid_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StStream;
          grant_d = NUM_PORTS'(1) << pick_idx;
          tid_d   = pick_idx;
        end
      end
      StStream: begin
        if (last_accept) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (tid_q == PW'(NUM_PORTS - 1)) ? '0 : tid_q + PW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      tid_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tid_q    <= tid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign m_tid = tid_q;
  assign busy  = streaming;

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Scoreboard bench: sources push expected beats per port and expected grant
// order; a negedge monitor pops and compares as beats leave the arbiter.
module tb_ingress_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  port_en;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, mr;
  logic [1:0]  m_tid;
  logic [3:0]  grant;
  logic        busy;

  logic [7:0]  td [4];
  logic        tv [4];
  logic        tl [4];

  // Second instance with three ports for the wrap case.
  logic [2:0]  en_b, tv_b, tl_b, tr_b, gnt_b;
  logic [23:0] td_b;
  logic [7:0]  md_b;
  logic        mv_b, ml_b, busy_b;
  logic [1:0]  tid_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats = 0;
  int last_cyc = 0;
  logic in_frame = 1'b0;
  logic have_last = 1'b0;
  logic gap_chk = 1'b0;
  logic done3 = 1'b0;
  logic [1:0] cur_tid = '0;

  logic [8:0] exp_q [4][$];
  int         exp_gnt [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < 4; i++) begin
      s_tdata[i*8 +: 8] = td[i];
      s_tvalid[i]       = tv[i];
      s_tlast[i]        = tl[i];
    end
  end

  ingress_frame_arbiter #(.NUM_PORTS(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(mr), .m_tid(m_tid), .grant(grant), .busy(busy)
  );

  ingress_frame_arbiter #(.NUM_PORTS(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .port_en(en_b), .s_tdata(td_b), .s_tvalid(tv_b),
    .s_tlast(tl_b), .s_tready(tr_b), .m_tdata(md_b), .m_tvalid(mv_b),
    .m_tlast(ml_b), .m_tready(1'b1), .m_tid(tid_b), .grant(gnt_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one frame on port p; optionally drop valid for 5 cycles before beat stall_at.
  task automatic send_frame(input int p, input int len, input logic [7:0] base,
                            input int stall_at);
    int waitc;
    for (int b = 0; b < len; b++) begin
      if (b == stall_at) begin
        tv[p] = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check_eq("hold_grant", 32'(grant), 32'(1) << p);
        end
      end
      tv[p] = 1'b1;
      td[p] = base + 8'(b);
      tl[p] = (b == len - 1);
      exp_q[p].push_back({tl[p], td[p]});
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
      end while (!s_tready[p] && waitc < 200);
      if (!s_tready[p]) begin
        check_eq("ready_timeout", 32'(0), 32'(1));
        tv[p] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tv[p] = 1'b0;
    tl[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: ready routing, grant order, beat contents, frame integrity, gaps.
  always @(negedge clk) begin
    logic [8:0] e;
    int g;
    if (!rst_n) begin
      in_frame  = 1'b0;
      have_last = 1'b0;
    end else begin
      check_eq("ready_route", 32'(s_tready), mr ? 32'(grant) : 32'(0));
      if (m_tvalid && mr) begin
        if (!in_frame) begin
          if (exp_gnt.size() > 0) begin
            g = exp_gnt.pop_front();
            check_eq("grant_order", 32'(m_tid), 32'(g));
          end else begin
            check_eq("unexpected_frame", 32'(m_tid), 32'hffff);
          end
          if (gap_chk && have_last) check_eq("frame_gap", 32'(cyc - last_cyc), 32'(2));
          in_frame = 1'b1;
          cur_tid  = m_tid;
        end else begin
          check_eq("tid_stable", 32'(m_tid), 32'(cur_tid));
        end
        check_eq("grant_onehot", 32'(grant), 32'(1) << m_tid);
        if (exp_q[m_tid].size() > 0) begin
          e = exp_q[m_tid].pop_front();
          check_eq("beat_data", 32'(m_tdata), 32'(e[7:0]));
          check_eq("beat_last", 32'(m_tlast), 32'(e[8]));
        end else begin
          check_eq("unexpected_beat", 32'(m_tdata), 32'hffff);
        end
        beats++;
        if (m_tlast) begin
          in_frame  = 1'b0;
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      td[i] = '0; tv[i] = 1'b0; tl[i] = 1'b0;
    end
    port_en = 4'hf; mr = 1'b1;
    en_b = 3'b111; tv_b = '0; tl_b = '0; td_b = '0;
    do_reset();

    // Reset state
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_tid", 32'(m_tid), 32'(0));
    check_eq("rst_tvalid", 32'(m_tvalid), 32'(0));
    check_eq("rst_tready", 32'(s_tready), 32'(0));
    check_eq("rst_rr", 32'(dut.rr_ptr_q), 32'(0));

    // Single port: port 2, 3 beats
    exp_gnt.push_back(2);
    fork
      send_frame(2, 3, 8'hA1, -1);
      begin
        @(posedge clk); #2;
        check_eq("t1_grant", 32'(grant), 32'h4);
        check_eq("t1_tid", 32'(m_tid), 32'(2));
        check_eq("t1_busy", 32'(busy), 32'(1));
      end
    join
    check_eq("t1_busy_drop", 32'(busy), 32'(0));
    check_eq("t1_grant_drop", 32'(grant), 32'(0));
    check_eq("t1_tid_hold", 32'(m_tid), 32'(2));
    check_eq("t1_rr", 32'(dut.rr_ptr_q), 32'(3));

    // All-request round robin from rr_ptr 0
    do_reset();
    gap_chk = 1'b1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(0);
    fork
      begin
        send_frame(0, 2, 8'h10, -1);
        send_frame(0, 2, 8'h50, -1);
      end
      send_frame(1, 2, 8'h20, -1);
      send_frame(2, 2, 8'h30, -1);
      send_frame(3, 2, 8'h40, -1);
    join
    gap_chk = 1'b0;
    check_eq("t2_rr", 32'(dut.rr_ptr_q), 32'(1));

    // Backpressure on a 4-beat frame from port 1
    exp_gnt.push_back(1);
    b0 = beats;
    fork
      begin
        send_frame(1, 4, 8'hB0, -1);
        done3 = 1'b1;
      end
      begin
        for (int i = 0; i < 60 && !done3; i++) begin
          mr = pat[i % 4];
          @(posedge clk); #1;
        end
        mr = 1'b1;
      end
    join
    check_eq("t3_xfers", 32'(beats - b0), 32'(4));
    check_eq("t3_rr", 32'(dut.rr_ptr_q), 32'(2));

    // No preemption; port_en cleared mid-frame
    exp_gnt.push_back(0); exp_gnt.push_back(3);
    fork
      send_frame(0, 3, 8'hC0, 1);
      begin
        for (int i = 0; i < 20 && !grant[0]; i++) begin
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
        port_en[0] = 1'b0;
        send_frame(3, 2, 8'hD0, -1);
      end
    join
    tv[0] = 1'b1; td[0] = 8'hEE; tl[0] = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("t4_disabled", 32'(busy), 32'(0));
    end
    tv[0] = 1'b0; tl[0] = 1'b0;
    port_en = 4'hf;

    // Wrap with NUM_PORTS=3 and single-beat frames
    td_b = {8'hE2, 8'hE1, 8'hE0};
    tv_b = 3'b100; tl_b = 3'b100;
    @(posedge clk); #1;
    check_eq("t5_grant2", 32'(gnt_b), 32'h4);
    check_eq("t5_data2", 32'(md_b), 32'hE2);
    check_eq("t5_last2", 32'(ml_b), 32'(1));
    @(posedge clk); #1;
    tv_b = 3'b000;
    check_eq("t5_busy", 32'(busy_b), 32'(0));
    check_eq("t5_rr_wrap", 32'(dut_b.rr_ptr_q), 32'(0));
    tv_b = 3'b101; tl_b = 3'b101;
    @(posedge clk); #1;
    check_eq("t5_grant0", 32'(gnt_b), 32'h1);
    check_eq("t5_tid0", 32'(tid_b), 32'(0));
    check_eq("t5_data0", 32'(md_b), 32'hE0);
    @(posedge clk); #1;
    tv_b = 3'b100;
    check_eq("t5_rr1", 32'(dut_b.rr_ptr_q), 32'(1));
    @(posedge clk); #1;
    check_eq("t5_grant2b", 32'(gnt_b), 32'h4);
    @(posedge clk); #1;
    tv_b = 3'b000; tl_b = 3'b000;

    // Reset mid-frame on port 1
    tv[1] = 1'b1; td[1] = 8'hF0; tl[1] = 1'b0;
    exp_q[1].push_back({1'b0, 8'hF0});
    exp_gnt.push_back(1);
    @(posedge clk); #1;
    check_eq("t6_grant", 32'(grant), 32'h2);
    @(posedge clk); #1;
    td[1] = 8'hF1;
    check_eq("t6_beat2_valid", 32'(m_tvalid), 32'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_grant_rst", 32'(grant), 32'(0));
    check_eq("t6_busy_rst", 32'(busy), 32'(0));
    check_eq("t6_tvalid_rst", 32'(m_tvalid), 32'(0));
    check_eq("t6_tready_rst", 32'(s_tready), 32'(0));
    check_eq("t6_rr_rst", 32'(dut.rr_ptr_q), 32'(0));
    rst_n = 1'b1; tv[1] = 1'b0;
    @(posedge clk); #1;
    exp_gnt.push_back(1);
    send_frame(1, 2, 8'h90, -1);
    check_eq("t6_busy_end", 32'(busy), 32'(0));
    check_eq("t6_rr_end", 32'(dut.rr_ptr_q), 32'(2));

    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) check_eq("exp_q_drained", 32'(exp_q[i].size()), 32'(0));
    check_eq("exp_gnt_drained", 32'(exp_gnt.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ingress_frame_arbiter.md
# ingress_frame_arbiter

- Shares the single Ethernet frame parser between `NUM_PORTS` AXI-Stream ingress ports.
- Grants are frame-granular and round-robin. Once a port is granted, it owns the parser input until its `tlast` beat is accepted.
- Sits directly upstream of the parser's beat-accept/tlast interface and tags each frame with its source port.

## Interface

Parameters:
- `NUM_PORTS`, default 4: number of requesting ingress ports. Must be ≥2.
- `DATA_W`, default 8: tdata width per port.

Derived:
- `PW = $clog2(NUM_PORTS)`.

Ports:
- Reset is synchronous and active-low.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous active-low reset.
- `port_en` in NUM_PORTS: per-port arbitration enable.
- `s_tdata` in NUM_PORTS*DATA_W: flattened port data. Port i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid` in NUM_PORTS: per-port valid.
- `s_tlast` in NUM_PORTS: per-port last.
- `s_tready` out NUM_PORTS: per-port ready.
- `m_tdata` out DATA_W: data to parser.
- `m_tvalid` out 1: valid to parser.
- `m_tlast` out 1: last to parser.
- `m_tready` in 1: parser ready.
- `m_tid` out PW: source port of the current frame.
- `grant` out NUM_PORTS: one-hot grant, registered.
- `busy` out 1: a frame is in progress.

## Operation

State machine has two states:
- IDLE: no grant. All `s_tready`=0, `m_tvalid`=0.
  - Request vector `req = s_tvalid & port_en`.
  - If `req` ≠ 0, choose the first set bit scanning from `rr_ptr` upward, modulo NUM_PORTS.
  - Register `grant` (one-hot), `m_tid` (index) and `busy`=1; go to STREAM.
- STREAM: combinational pass-through for granted port g.
  - `m_tdata`/`m_tvalid`/`m_tlast` = port g's signals.
  - `s_tready[g]` = `m_tready`. All other `s_tready` = 0.
  - Accepted beat = `m_tvalid & m_tready`.
  - On an accepted beat with `m_tlast`=1: next cycle is IDLE, `grant`=0, `busy`=0, and `rr_ptr` = (g+1) mod NUM_PORTS.

Rules:
- `rr_ptr` is a PW-bit register.
- Wrap: when g = NUM_PORTS-1, the next `rr_ptr` is 0. The modulo must be correct for non-power-of-two NUM_PORTS; `rr_ptr` never takes a value ≥ NUM_PORTS.
- No preemption: deasserting `port_en[g]` or `s_tvalid[g]` mid-frame does not release the grant. The arbiter waits in STREAM indefinitely.
- `port_en` only affects new grants in IDLE.
- A single-beat frame (`tlast` on the first beat) is legal and behaves as above.
- Ungranted ports are never acknowledged, regardless of their valid.
- `m_tid` holds its value after the frame ends, until the next grant.
- A frame must never contain beats from two ports.

## Timing

- Reset values (`rst_n`=0 at a clk edge): state IDLE, `grant`=0, `busy`=0, `m_tid`=0, `rr_ptr`=0. This makes `m_tvalid`=0 and `s_tready`=0.
- Reset mid-frame aborts the frame. The parser sees `m_tvalid` drop with no `tlast`; the parser is reset by the same `rst_n`.
- Arbitration latency: request seen in IDLE at cycle N; `grant` and `busy` high at N+1. The first beat can transfer at N+1.
- Data path latency: 0 cycles. `m_*` and `s_tready` are combinational through the grant mux. The only registered outputs are `grant`, `m_tid` and `busy`.
- Inter-frame gap: exactly 1 IDLE cycle after each `tlast` acceptance. Peak throughput is L/(L+1) beats/cycle for L-beat frames.
- Simultaneous requests in IDLE are resolved purely by `rr_ptr` order.
- Requests arriving during STREAM wait for IDLE.
- If `m_tready`=0, the granted port's beat holds (AXI rules). The arbiter adds no buffering.

## Test plan

- **Single port:** after reset, port 2 sends a 3-beat frame (0xA1, 0xA2, 0xA3+last), `m_tready`=1.
  - Response: `grant`=4'b0100 and `m_tid`=2 one cycle after valid; 3 beats pass unchanged; `busy` drops the cycle after the last beat; `rr_ptr`=3.
- **All-request round-robin:** all 4 ports continuously send 2-beat frames.
  - Response: grant order 0,1,2,3,0; a 1-cycle gap between frames; no interleaving of beats.
- **Backpressure:** `m_tready` toggles 1,0,0,1 during a 4-beat frame from port 1.
  - Response: `s_tready[1]` mirrors `m_tready`; exactly 4 transfers; `s_tready` for ports 0, 2 and 3 stays 0 throughout.
- **No preemption / enable:** port 0 is granted, then drops `s_tvalid` for 5 cycles and `port_en[0]` is cleared mid-frame, while port 3 requests.
  - Response: grant stays on port 0 until its `tlast`, then goes to port 3. Port 0 is not granted again while `port_en[0]`=0.
- **Wrap and single-beat frames:** NUM_PORTS=3, port 2 sends a 1-beat frame, then ports 0 and 2 request together.
  - Response: `rr_ptr` wraps to 0 and port 0 is granted first.
- **Reset mid-frame:** assert `rst_n`=0 during beat 2 of a port 1 frame.
  - Response: at the next edge `grant`=0, `busy`=0, `m_tvalid`=0, `rr_ptr`=0. After release, the next request from port 1 is granted cleanly.
